fwd_hazard_ctrl: RTL

- Sequential forwarding and hazard controller for the execute stage of the pipeline.
- Tracks destination registers of in-flight instructions in EX, MEM and WB shadow records.
- Drives the 2-bit select lines of the two 32-bit 3-input operand muxes placed directly downstream.
- Raises a load-use stall toward fetch/decode.

---
 rtl/fwd_hazard_ctrl_if.sv | 33 +++
 rtl/fwd_hazard_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side bus between ID stage and the forwarding/hazard controller
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_is_load;
  logic                  flush;
  logic                  stall_out;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic [CNT_W-1:0]      stall_count;

  // Decode side: presents the instruction, observes stall and selects
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_reg_write, id_is_load, flush,
    input  stall_out, fwd_sel_a, fwd_sel_b, stall_count
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_write, id_is_load, flush,
    output stall_out, fwd_sel_a, fwd_sel_b, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage operand forwarding selects and load-use stall generation
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'd0;  // register-file value
  localparam logic [1:0] SEL_MEM = 2'd1;  // EX/MEM result
  localparam logic [1:0] SEL_WB  = 2'd2;  // MEM/WB result

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } rec_t;

  typedef struct packed {
    rec_t                  base;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } ex_rec_t;

  ex_rec_t          r_ex;
  rec_t             r_mem;
  rec_t             r_wb;
  logic [1:0]       r_sel_a;
  logic [1:0]       r_sel_b;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_ex_hit_rs1;
  logic             w_ex_hit_rs2;
  logic             w_stall;
  logic             w_capture;
  ex_rec_t          w_ex_next;
  logic [1:0]       w_sel_a_next;
  logic [1:0]       w_sel_b_next;
  logic             w_unused;

  // A record produces register s when it is live, writes, targets s, and s is not r0
  function automatic logic writes(input rec_t r, input logic [REG_ADDR_W-1:0] s);
    return r.valid & r.reg_write & (r.rd == s) & (s != '0);
  endfunction

  // Youngest producer wins: the instruction in EX moves to MEM, the one in MEM moves to WB
  function automatic logic [1:0] pick_sel(input logic used,
                                          input logic [REG_ADDR_W-1:0] s,
                                          input rec_t ex,
                                          input rec_t mem);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (writes(ex, s))       sel = SEL_MEM;
      else if (writes(mem, s)) sel = SEL_WB;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in EX
  always_comb begin
    w_ex_hit_rs1 = bus.id_rs1_used & writes(r_ex.base, bus.id_rs1);
    w_ex_hit_rs2 = bus.id_rs2_used & writes(r_ex.base, bus.id_rs2);
    w_stall      = ~bus.flush & bus.id_valid & r_ex.base.is_load & (w_ex_hit_rs1 | w_ex_hit_rs2);
    // Flush outranks stall; either one puts a bubble into EX
    w_capture    = ~bus.flush & ~w_stall;
  end

  // Next EX record and the selects that travel with it into EX
  always_comb begin
    w_ex_next    = '0;
    w_sel_a_next = SEL_RF;
    w_sel_b_next = SEL_RF;
    if (w_capture) begin
      w_ex_next.base.valid     = bus.id_valid;
      w_ex_next.base.rd        = bus.id_rd;
      w_ex_next.base.reg_write = bus.id_reg_write;
      w_ex_next.base.is_load   = bus.id_is_load;
      w_ex_next.rs1            = bus.id_rs1;
      w_ex_next.rs2            = bus.id_rs2;
      w_ex_next.rs1_used       = bus.id_rs1_used;
      w_ex_next.rs2_used       = bus.id_rs2_used;
      if (bus.id_valid) begin
        // A load in EX never reaches here with a matching consumer (it stalls), so SEL_MEM
        // is never chosen for a load producer.
        w_sel_a_next = pick_sel(bus.id_rs1_used, bus.id_rs1, r_ex.base, r_mem);
        w_sel_b_next = pick_sel(bus.id_rs2_used, bus.id_rs2, r_ex.base, r_mem);
      end
    end
  end

  // Pipeline shadow records: MEM->WB and EX->MEM always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex.base;
      r_ex  <= w_ex_next;
    end
  end

  // Registered operand-mux selects, aligned with the instruction now in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else begin
      r_sel_a <= w_sel_a_next;
      r_sel_b <= w_sel_b_next;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.stall_out   = w_stall;
  assign bus.fwd_sel_a   = r_sel_a;
  assign bus.fwd_sel_b   = r_sel_b;
  assign bus.stall_count = r_stall_count;

  // WB record, EX source fields and MEM load flag are tracked for debug visibility only
  assign w_unused = ^{r_wb, r_ex.rs1, r_ex.rs2, r_ex.rs1_used, r_ex.rs2_used, r_mem.is_load};

endmodule
